ss_sort_engine: RTL

Selection-sort core. Consumes the held start level produced by the sort start detector, sorts `DEPTH` unsigned words in place in an external single-port-read / single-port-write synchronous RAM, and returns a one-cycle `o_done` pulse. The start detector consumes `o_done` to drop the start level. Order is ascending; among equal values, the earliest index is kept as the minimum.

---
 rtl/ss_pkg.sv | 25 ++
 rtl/ss_min_tracker.sv | 52 +++++
 rtl/ss_sort_engine.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// Shared types and helpers for the selection-sort engine.
// Holds the FSM state encoding and the address-width helper.
package ss_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        LD_I,
        RD_J,
        CMP_J,
        SWAP_I,
        SWAP_M,
        NEXT,
        DONE
    } ss_sort_state_e;

    localparam int SS_DEFAULT_DATA_WIDTH = 32;
    localparam int SS_DEFAULT_DEPTH      = 16;

    // Address width for a given depth; never narrower than one bit.
    function automatic int ss_addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ss_min_tracker.sv
// Running-minimum register pair for the selection-sort scan.
// Load seeds the candidate; compare replaces it only on a strictly smaller value.
module ss_min_tracker
    import ss_pkg::*;
#(
    parameter int DATA_WIDTH = SS_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = ss_addr_width(SS_DEFAULT_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_val,
    input  logic [ADDR_WIDTH-1:0] i_load_idx,
    input  logic                  i_cmp,
    input  logic [DATA_WIDTH-1:0] i_cmp_val,
    input  logic [ADDR_WIDTH-1:0] i_cmp_idx,
    output logic [DATA_WIDTH-1:0] o_min_val,
    output logic [ADDR_WIDTH-1:0] o_min_idx,
    output logic [ADDR_WIDTH-1:0] o_min_idx_next
);

    logic [DATA_WIDTH-1:0] min_val_q, min_val_d;
    logic [ADDR_WIDTH-1:0] min_idx_q, min_idx_d;

    // Strict less-than keeps the earliest index among equal values.
    always_comb begin
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;
        if (i_load) begin
            min_val_d = i_load_val;
            min_idx_d = i_load_idx;
        end else if (i_cmp && (i_cmp_val < min_val_q)) begin
            min_val_d = i_cmp_val;
            min_idx_d = i_cmp_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            min_val_q <= '0;
            min_idx_q <= '0;
        end else begin
            min_val_q <= min_val_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign o_min_val      = min_val_q;
    assign o_min_idx      = min_idx_q;
    assign o_min_idx_next = min_idx_d;

endmodule

// File: rtl/ss_sort_engine.sv
// In-place ascending selection sort over an external 1-cycle-latency RAM.
// Starts on a rising edge of the held start level, pulses o_done when finished.
module ss_sort_engine
    import ss_pkg::*;
#(
    parameter int DATA_WIDTH = SS_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = SS_DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = ss_addr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_J     = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_I     = ADDR_WIDTH'(DEPTH - 2);

    ss_sort_state_e        state_q, state_d;
    logic                  start_q;
    logic [ADDR_WIDTH-1:0] i_idx_q, i_idx_d;
    logic [ADDR_WIDTH-1:0] j_idx_q, j_idx_d;
    logic [DATA_WIDTH-1:0] cur_val_q, cur_val_d;

    logic                  min_load, min_cmp;
    logic [DATA_WIDTH-1:0] min_val;
    logic [ADDR_WIDTH-1:0] min_idx, min_idx_next;

    ss_min_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_min (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load         (min_load),
        .i_load_val     (i_rd_data),
        .i_load_idx     (i_idx_q),
        .i_cmp          (min_cmp),
        .i_cmp_val      (i_rd_data),
        .i_cmp_idx      (j_idx_q),
        .o_min_val      (min_val),
        .o_min_idx      (min_idx),
        .o_min_idx_next (min_idx_next)
    );

    always_comb begin
        state_d   = state_q;
        i_idx_d   = i_idx_q;
        j_idx_d   = j_idx_q;
        cur_val_d = cur_val_q;
        min_load  = 1'b0;
        min_cmp   = 1'b0;
        o_done    = 1'b0;
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;

        unique case (state_q)
            IDLE: begin
                if (i_start && !start_q) begin
                    i_idx_d = '0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                o_rd_en   = 1'b1;
                o_rd_addr = i_idx_q;
                state_d   = LD_I;
            end
            LD_I: begin
                cur_val_d = i_rd_data;
                min_load  = 1'b1;
                j_idx_d   = i_idx_q + IDX_ONE;
                state_d   = RD_J;
            end
            RD_J: begin
                o_rd_en   = 1'b1;
                o_rd_addr = j_idx_q;
                state_d   = CMP_J;
            end
            CMP_J: begin
                min_cmp = 1'b1;
                // The swap decision must see this cycle's compare result.
                if (j_idx_q == LAST_J) begin
                    state_d = (min_idx_next != i_idx_q) ? SWAP_I : NEXT;
                end else begin
                    j_idx_d = j_idx_q + IDX_ONE;
                    state_d = RD_J;
                end
            end
            SWAP_I: begin
                o_wr_en   = 1'b1;
                o_wr_addr = i_idx_q;
                o_wr_data = min_val;
                state_d   = SWAP_M;
            end
            SWAP_M: begin
                o_wr_en   = 1'b1;
                o_wr_addr = min_idx;
                o_wr_data = cur_val_q;
                state_d   = NEXT;
            end
            NEXT: begin
                if (i_idx_q == LAST_I) begin
                    state_d = DONE;
                end else begin
                    i_idx_d = i_idx_q + IDX_ONE;
                    state_d = RD_I;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            i_idx_q   <= '0;
            j_idx_q   <= '0;
            cur_val_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= i_start;
            i_idx_q   <= i_idx_d;
            j_idx_q   <= j_idx_d;
            cur_val_q <= cur_val_d;
        end
    end

endmodule
